// File: rtl/led_sequencer.sv
// led_sequencer: steps an LED pattern table out to a PIO slave.
// Once CTRL.enable is set from idle, the block issues one PIO write of
// PATTERN[step]. It then waits max(PERIOD,1) cycles and moves to the next
// step. It stops after LENGTH steps, or restarts from step 0 if loop is set.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   address         CPU register select (word address)
//   chipselect      CPU slave select
//   write_n         CPU write strobe, active-low
//   writedata       CPU write data
//   readdata        CPU read data, combinational from address, zero-extended
//   pio_address     PIO register select, tied to 0
//   pio_chipselect  PIO select, high only during a PIO write
//   pio_write_n     PIO write strobe, active-low
//   pio_writedata   PIO data, pattern in [LED_W-1:0]
//   irq             (LED_SEQUENCER_IRQ_EN only) registered done & CTRL.irq_en
//
// Register map: 0 CTRL {irq_en, loop, enable}; 1 STATUS {step[7:4], done[1],
// running[0]}; 2 PERIOD; 3 LENGTH; 8.. PATTERN[i].
// Optional feature macro: LED_SEQUENCER_IRQ_EN.
module led_sequencer #(
    parameter int STEPS    = 8,
    parameter int PERIOD_W = 24,
    parameter int LED_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
`ifdef LED_SEQUENCER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t              state, state_next;
    logic                ctrl_enable, ctrl_loop, irq_en_bit;
    logic                done, done_next;
    logic [3:0]          step;
    logic [PERIOD_W-1:0] counter, period, period_now, period_last;
    logic [4:0]          length, len_eff;
    logic [LED_W-1:0]    pattern [STEPS];

    logic wr, wr_ctrl, wr_status, wr_period, wr_length, pat_hit, wr_pat;
    logic start, abort, expired, last_step, finish, advance, wrap;
    logic [IDX_W-1:0] pat_idx;
    logic unused_wd;

    assign unused_wd = ^writedata;

    // CPU decode
    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == 4'd0);
    assign wr_status = wr && (address == 4'd1);
    assign wr_period = wr && (address == 4'd2);
    assign wr_length = wr && (address == 4'd3);
    // Only PATTERN[0..7] fit in the 4-bit address space above offset 8.
    assign pat_hit   = address[3] && (int'({1'b0, address[2:0]}) < STEPS);
    assign wr_pat    = wr && pat_hit;
    assign pat_idx   = IDX_W'(address[2:0]);

    assign start = wr_ctrl && writedata[0];
    assign abort = wr_ctrl && !writedata[0];

    // A PERIOD write in the current cycle is compared at once, so shrinking
    // the period below the running count ends the wait on this very cycle.
    assign period_now  = wr_period ? writedata[PERIOD_W-1:0] : period;
    assign period_last = (period_now == '0) ? '0 : period_now - PERIOD_W'(1);
    assign expired     = (counter >= period_last);

    always_comb begin
        if (length == 5'd0 || int'(length) > STEPS) len_eff = 5'(STEPS);
        else                                         len_eff = length;
    end

    assign last_step = ({1'b0, step} == len_eff - 5'd1);
    assign advance   = (state == WAIT) && !abort && expired;
    assign finish    = advance && last_step && !ctrl_loop;
    assign wrap      = advance && last_step && ctrl_loop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   state_next = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)       state_next = IDLE;
                else if (finish) state_next = IDLE;
                else if (expired) state_next = WRITE;
            end
            default: state_next = IDLE;
        endcase
    end

    // PIO outputs; reset suppresses a write that would land in its cycle
    always_comb begin
        pio_address    = 2'b00;
        pio_chipselect = (state == WRITE) && !reset;
        pio_write_n    = !pio_chipselect;
        pio_writedata  = '0;
        if (pio_chipselect) pio_writedata[LED_W-1:0] = pattern[step[IDX_W-1:0]];
    end

    // done: set on completion beats a same-cycle clear
    always_comb begin
        done_next = done;
        if (wr_status && writedata[1])   done_next = 1'b0;
        if ((state == IDLE) && start)    done_next = 1'b0;
        if (finish)                      done_next = 1'b1;
    end

    // Datapath and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_loop   <= 1'b0;
            done        <= 1'b0;
            step        <= '0;
            counter     <= '0;
            period      <= PERIOD_W'(1);
            length      <= '0;
            for (int unsigned i = 0; i < unsigned'(STEPS); i++) pattern[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= writedata[0];
                ctrl_loop   <= writedata[1];
            end
            if (finish)    ctrl_enable <= 1'b0;
            if (wr_period) period <= writedata[PERIOD_W-1:0];
            if (wr_length) length <= writedata[4:0];
            if (wr_pat)    pattern[pat_idx] <= writedata[LED_W-1:0];
            done <= done_next;

            if ((state == IDLE) && start)    step <= '0;
            else if (wrap)                   step <= '0;
            else if (advance && !last_step)  step <= step + 4'd1;

            if (state == WRITE)     counter <= '0;
            else if (state == WAIT) counter <= counter + PERIOD_W'(1);
        end
    end

`ifdef LED_SEQUENCER_IRQ_EN
    logic ctrl_irq_en, irq_en_next;
    assign irq_en_next = wr_ctrl ? writedata[2] : ctrl_irq_en;
    assign irq_en_bit  = ctrl_irq_en;

    // Registered from next-cycle values so irq tracks done without extra lag
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ctrl_irq_en <= irq_en_next;
            irq         <= done_next && irq_en_next;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    // CPU read mux
    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[2:0] = {irq_en_bit, ctrl_loop, ctrl_enable};
            4'd1: readdata[7:0] = {step, 2'b00, done, (state != IDLE)};
            4'd2: readdata[PERIOD_W-1:0] = period;
            4'd3: readdata[4:0] = length;
            default: if (pat_hit) readdata[LED_W-1:0] = pattern[pat_idx];
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
`timescale 1ns/1ps
module tb_led_sequencer;
    localparam int STEPS    = 8;
    localparam int PERIOD_W = 24;
    localparam int LED_W    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
`ifdef LED_SEQUENCER_IRQ_EN
    logic        irq;
`endif

    led_sequencer #(.STEPS(STEPS), .PERIOD_W(PERIOD_W), .LED_W(LED_W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata)
`ifdef LED_SEQUENCER_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observed PIO writes: cycle number and data
    typedef struct { int c; logic [31:0] d; } pio_ev_t;
    pio_ev_t obs_q[$];

    always @(negedge clk) begin
        if (pio_chipselect === 1'b1) begin
            obs_q.push_back('{cyc, pio_writedata});
            check("pio_write_n during write", {31'b0, pio_write_n}, 32'd0);
            check("pio_address during write", {30'b0, pio_address}, 32'd0);
        end
    end

    // Reference register model
    int          m_period;
    int          m_length;
    logic [31:0] m_pat [STEPS];

    task automatic model_reset();
        m_period = 1;
        m_length = 0;
        for (int i = 0; i < STEPS; i++) m_pat[i] = '0;
    endtask

    // Bus tasks: caller sits in the low clock phase; a write occupies one cycle
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int c);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        c = cyc;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1 d = readdata;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        int t;
        bus_write(a, d, t);
        if (a == 4'd2) m_period = int'(d[PERIOD_W-1:0]);
        if (a == 4'd3) m_length = int'(d[4:0]);
        if (a >= 4'd8 && int'(a) - 8 < STEPS) m_pat[int'(a) - 8] = d & ((32'd1 << LED_W) - 32'd1);
    endtask

    task automatic wait_to(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // One non-looping run: writes expected at t0+1+k*(max(P,1)+1)
    task automatic run_once(input string tag, input bit poke);
        int pe, len, t0, t_end, tmp;
        logic [31:0] st;
        pe  = (m_period == 0) ? 1 : m_period;
        len = (m_length == 0 || m_length > STEPS) ? STEPS : m_length;
        obs_q.delete();
        bus_write(4'd0, 32'd1, t0);
        t_end = t0 + 1 + len * (pe + 1);
        if (poke && (t_end - 4 >= t0 + 1)) begin
            wait_to($urandom_range(t_end - 4, t0 + 1));
            bus_write(4'd0, 32'd1, tmp);
        end
        wait_to(t_end - 2);
        bus_read(4'd1, st);
        check({tag, " status last wait"}, st, 32'(((len - 1) << 4) | 1));
        bus_read(4'd1, st);
        check({tag, " status done"}, st, 32'(((len - 1) << 4) | 2));
        wait_to(t_end + 3);
        check({tag, " write count"}, obs_q.size(), len);
        for (int k = 0; k < len && k < obs_q.size(); k++) begin
            check({tag, " write cycle"}, obs_q[k].c, t0 + 1 + k * (pe + 1));
            check({tag, " write data"}, obs_q[k].d, m_pat[k]);
        end
        bus_read(4'd0, st);
        check({tag, " ctrl after run"}, st, 32'd0);
    endtask

    logic [31:0] rd;
    int          t0, w, tmp;

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset pio_chipselect", {31'b0, pio_chipselect}, 32'd0);
        check("reset pio_write_n", {31'b0, pio_write_n}, 32'd1);
        check("reset pio_writedata", pio_writedata, 32'd0);
        check("reset pio_address", {30'b0, pio_address}, 32'd0);
`ifdef LED_SEQUENCER_IRQ_EN
        check("reset irq", {31'b0, irq}, 32'd0);
`endif
        bus_read(4'd0, rd); check("reset CTRL", rd, 32'd0);
        bus_read(4'd1, rd); check("reset STATUS", rd, 32'd0);
        bus_read(4'd2, rd); check("reset PERIOD", rd, 32'd1);
        bus_read(4'd3, rd); check("reset LENGTH", rd, 32'd0);
        bus_read(4'd8, rd); check("reset PATTERN0", rd, 32'd0);
        bus_read(4'd15, rd); check("reset PATTERN7", rd, 32'd0);

        // Basic four-step sequence
        cfg_write(4'd2, 32'd3); cfg_write(4'd3, 32'd4);
        cfg_write(4'd8, 32'd1); cfg_write(4'd9, 32'd2);
        cfg_write(4'd10, 32'd3); cfg_write(4'd11, 32'd0);
        run_once("basic", 1'b0);

        // Looping run aborted after the sixth write
        obs_q.delete();
        bus_write(4'd0, 32'd3, t0);
        wait_to(t0 + 22);
        bus_write(4'd0, 32'd0, tmp);
        wait_to(t0 + 40);
        check("loop write count", obs_q.size(), 6);
        for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
            check("loop write cycle", obs_q[k].c, t0 + 1 + 4 * k);
            check("loop write data", obs_q[k].d, m_pat[k % 4]);
        end
        bus_read(4'd1, rd); check("loop abort status", rd, 32'h10);

        // PERIOD 0 and LENGTH 0: all steps, two cycles apart
        cfg_write(4'd2, 32'd0); cfg_write(4'd3, 32'd0);
        for (int i = 0; i < STEPS; i++) cfg_write(4'(8 + i), $urandom);
        run_once("period0", 1'b0);

        // Shrinking PERIOD mid-wait
        cfg_write(4'd2, 32'd10); cfg_write(4'd3, 32'd4);
        obs_q.delete();
        bus_write(4'd0, 32'd1, t0);
        w = t0 + 1;
        wait_to(w + 6);
        cfg_write(4'd2, 32'd2);
        wait_to(w + 20);
        check("shrink write count", obs_q.size(), 4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            check("shrink write cycle", obs_q[k].c, (k == 0) ? w : w + 4 + 3 * k);
            check("shrink write data", obs_q[k].d, m_pat[k]);
        end
        bus_read(4'd1, rd); check("shrink status", rd, 32'h32);

        // STATUS done clear, unmapped addresses, CTRL bit2
        bus_write(4'd1, 32'd0, tmp);
        bus_read(4'd1, rd); check("status write 0 keeps done", rd, 32'h32);
        bus_write(4'd1, 32'd2, tmp);
        bus_read(4'd1, rd); check("status clear done", rd, 32'h30);
        bus_write(4'd5, 32'hFFFF_FFFF, tmp);
        bus_read(4'd5, rd); check("unmapped 5", rd, 32'd0);
        bus_read(4'd4, rd); check("unmapped 4", rd, 32'd0);
        bus_write(4'd0, 32'd6, tmp);
        bus_read(4'd0, rd);
`ifdef LED_SEQUENCER_IRQ_EN
        check("ctrl readback", rd, 32'd6);
`else
        check("ctrl readback", rd, 32'd2);
`endif
        bus_write(4'd0, 32'd0, tmp);

        // Randomized runs with a redundant enable write mid-run
        for (int r = 0; r < 8; r++) begin
            int pi;
            cfg_write(4'd2, $urandom_range(6, 0));
            cfg_write(4'd3, $urandom_range(31, 0));
            for (int i = 0; i < STEPS; i++) cfg_write(4'(8 + i), $urandom);
            pi = $urandom_range(STEPS - 1, 0);
            bus_read(4'(8 + pi), rd); check("pattern readback", rd, m_pat[pi]);
            run_once("random", 1'b1);
        end

`ifdef LED_SEQUENCER_IRQ_EN
        cfg_write(4'd2, 32'd2); cfg_write(4'd3, 32'd1);
        bus_write(4'd0, 32'd5, tmp);
        repeat (8) @(negedge clk);
        check("irq after run", {31'b0, irq}, 32'd1);
        bus_write(4'd1, 32'd2, tmp);
        check("irq after clear", {31'b0, irq}, 32'd0);
`endif

        // Reset mid-run: variant 0 lands in WAIT, variant 1 in a WRITE cycle
        for (int v = 0; v < 2; v++) begin
            cfg_write(4'd2, 32'd3); cfg_write(4'd3, 32'd0);
            obs_q.delete();
            bus_write(4'd0, 32'd1, t0);
            w = t0 + 1;
            wait_to((v == 0) ? w + 1 : w + 3);
            @(posedge clk); #1 reset = 1'b1;
            @(negedge clk);
            check("reset pio_chipselect mid-run", {31'b0, pio_chipselect}, 32'd0);
            check("reset pio_write_n mid-run", {31'b0, pio_write_n}, 32'd1);
            check("reset pio_writedata mid-run", pio_writedata, 32'd0);
            @(posedge clk); #1 reset = 1'b0;
            model_reset();
            repeat (15) @(negedge clk);
            check("reset write count", obs_q.size(), 1);
            bus_read(4'd1, rd); check("reset STATUS mid-run", rd, 32'd0);
            bus_read(4'd2, rd); check("reset PERIOD mid-run", rd, 32'd1);
            bus_read(4'd0, rd); check("reset CTRL mid-run", rd, 32'd0);
            bus_read(4'd9, rd); check("reset PATTERN1 mid-run", rd, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
